// File: rtl/uart_tx.sv
// 8N1 UART transmitter for a 50 MHz clock with five selectable baud rates.
// The byte and baud selection are captured on acceptance, so the frame in flight ignores input changes.
`timescale 1ns/1ps
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  output logic       rs232_Tx,
  output logic       tx_done,
  output logic       uart_state,
  output logic       bps_clk
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [12:0] div_lim_q, div_lim_d;
  logic [12:0] div_cnt_q, div_cnt_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  bps_cnt_q, bps_cnt_d;
  logic        bps_clk_q, bps_clk_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        start;
  logic        frame_end;
  logic [3:0]  bit_idx;

  // Terminal count of the divider (bit period minus one) at 50 MHz.
  function automatic logic [12:0] div_limit(input logic [2:0] sel);
    case (sel)
      3'd1:    div_limit = 13'd2603;
      3'd2:    div_limit = 13'd1301;
      3'd3:    div_limit = 13'd867;
      3'd4:    div_limit = 13'd433;
      default: div_limit = 13'd5207;
    endcase
  endfunction

  assign start     = (state_q == S_IDLE) && send_en;
  // The eleventh tick ends the stop bit; the frame closes on that same edge.
  assign frame_end = (state_q == S_BUSY) && bps_clk_q && (bps_cnt_q == 4'd10);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_lim_q <= 13'd0;
      div_cnt_q <= 13'd0;
      data_q    <= 8'd0;
      bps_cnt_q <= 4'd0;
      bps_clk_q <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_lim_q <= div_lim_d;
      div_cnt_q <= div_cnt_d;
      data_q    <= data_d;
      bps_cnt_q <= bps_cnt_d;
      bps_clk_q <= bps_clk_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (frame_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: divider, bit counter, line and strobes
  always_comb begin
    div_lim_d = div_lim_q;
    div_cnt_d = div_cnt_q;
    data_d    = data_q;
    bps_cnt_d = bps_cnt_q;
    bps_clk_d = 1'b0;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    bit_idx   = 4'd0;

    if (start) begin
      data_d    = data_byte;
      div_lim_d = div_limit(baud_set);
      div_cnt_d = 13'd0;
      bps_cnt_d = 4'd0;
    end else if (frame_end) begin
      div_cnt_d = 13'd0;
      bps_cnt_d = 4'd0;
      done_d    = 1'b1;
    end else if (state_q == S_BUSY) begin
      div_cnt_d = (div_cnt_q == div_lim_q) ? 13'd0 : div_cnt_q + 13'd1;
      bps_clk_d = (div_cnt_q == 13'd1);
      if (bps_clk_q) bps_cnt_d = bps_cnt_q + 4'd1;
    end

    // The line is driven from the counter value being loaded, so each bit
    // appears on the same edge that advances the counter.
    bit_idx = bps_cnt_d - 4'd2;
    if (state_q == S_BUSY && !frame_end) begin
      case (bps_cnt_d)
        4'd1:                                   tx_d = 1'b0;
        4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9:                 tx_d = data_q[bit_idx[2:0]];
        default:                                tx_d = 1'b1;
      endcase
    end
  end

  // Outputs
  always_comb begin
    uart_state = (state_q == S_BUSY);
    rs232_Tx   = tx_q;
    tx_done    = done_q;
    bps_clk    = bps_clk_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame bit timing at several baud rates, back-to-back,
// mid-frame disturbance and asynchronous mid-frame reset.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       send_en;
  logic       rs232_Tx;
  logic       tx_done;
  logic       uart_state;
  logic       bps_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k_acc = 0;
  int bps_seen = 0;
  int done_seen = 0;
  int idle_bps = 0;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .send_en    (send_en),
    .rs232_Tx   (rs232_Tx),
    .tx_done    (tx_done),
    .uart_state (uart_state),
    .bps_clk    (bps_clk)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bps_clk) bps_seen <= bps_seen + 1;
    if (tx_done) done_seen <= done_seen + 1;
    if (bps_clk && !uart_state) idle_bps <= idle_bps + 1;
  end

  initial begin
    #1950000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
    if (cyc != target) check_val("sched", 16'(cyc), 16'(target));
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [2:0] b);
    @(negedge clk);
    data_byte = d;
    baud_set  = b;
    send_en   = 1'b1;
    @(negedge clk);
    send_en = 1'b0;
    k_acc   = cyc;
    check_val("accept_state", 16'(uart_state), 16'd1);
  endtask

  // exp_line bit i is the line level during bit slot i (0 = start, 9 = stop).
  task automatic check_frame(input logic [9:0] exp_line, input int n, input bit disturb,
                             input bit chain, input logic [7:0] nd, input logic [2:0] nb);
    int k;
    int s;
    int bps_base;
    int done_base;
    k = k_acc;
    bps_base  = bps_seen;
    done_base = done_seen;
    wait_until(k + 1);
    check_val("bps_k1", 16'(bps_clk), 16'd0);
    wait_until(k + 2);
    check_val("bps_first", 16'(bps_clk), 16'd1);
    check_val("tx_pre", 16'(rs232_Tx), 16'd1);
    for (int i = 0; i < 10; i++) begin
      s = k + 3 + i * n;
      wait_until(s);
      check_val("bit_first", 16'({1'b1, exp_line[i]}), 16'({uart_state, rs232_Tx}));
      wait_until(s + n / 2);
      check_val("bit_mid", 16'({uart_state, rs232_Tx}), 16'({1'b1, exp_line[i]}));
      if (disturb && i == 3) begin
        send_en   = 1'b1;
        data_byte = ~data_byte;
        baud_set  = 3'd0;
        @(negedge clk);
        send_en = 1'b0;
      end
      wait_until(s + n - 1);
      check_val("bit_last", 16'({uart_state, rs232_Tx}), 16'({1'b1, exp_line[i]}));
    end
    wait_until(k + 3 + 10 * n);
    check_val("done_hi", 16'({tx_done, uart_state, rs232_Tx}), 16'b101);
    if (chain) begin
      data_byte = nd;
      baud_set  = nb;
      send_en   = 1'b1;
    end
    wait_until(k + 4 + 10 * n);
    check_val("done_lo", 16'(tx_done), 16'd0);
    check_val("done_count", 16'(done_seen - done_base), 16'd1);
    check_val("bps_count", 16'(bps_seen - bps_base), 16'd11);
    if (chain) begin
      send_en = 1'b0;
      check_val("b2b_state", 16'(uart_state), 16'd1);
      k_acc = cyc;
    end else begin
      check_val("idle_state", 16'(uart_state), 16'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_async", 16'({uart_state, rs232_Tx, tx_done, bps_clk}), 16'b0100);
    @(negedge clk);
    @(negedge clk);
    check_val("rst_hold", 16'({uart_state, rs232_Tx, tx_done, bps_clk}), 16'b0100);
    rst = 1'b1;
  endtask

  // Start a frame, verify the start-bit length equals n, then abort by reset.
  task automatic probe_period(input logic [2:0] b, input int n);
    int k;
    int done_base;
    start_frame(8'h01, b);
    k = k_acc;
    done_base = done_seen;
    wait_until(k + 2);
    check_val("probe_bps", 16'(bps_clk), 16'd1);
    wait_until(k + 3);
    check_val("probe_start", 16'(rs232_Tx), 16'd0);
    wait_until(k + 2 + n);
    check_val("probe_start_end", 16'(rs232_Tx), 16'd0);
    wait_until(k + 3 + n);
    check_val("probe_d0", 16'(rs232_Tx), 16'd1);
    pulse_reset();
    check_val("probe_no_done", 16'(done_seen - done_base), 16'd0);
  endtask

  initial begin
    int k;
    int done_base;
    rst       = 1'b0;
    send_en   = 1'b0;
    data_byte = 8'h00;
    baud_set  = 3'd0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("reset", 16'({rs232_Tx, tx_done, uart_state, bps_clk}), 16'b1000);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);

    start_frame(8'hAA, 3'd0);
    check_frame(10'b1101010100, 5208, 1'b0, 1'b0, 8'h00, 3'd0);

    repeat (200) @(negedge clk);
    check_val("gap_idle", 16'({uart_state, rs232_Tx}), 16'b01);

    start_frame(8'hE0, 3'd4);
    check_frame(10'b1111000000, 434, 1'b0, 1'b1, 8'h55, 3'd4);
    check_frame(10'b1010101010, 434, 1'b0, 1'b0, 8'h00, 3'd0);

    repeat (200) @(negedge clk);
    start_frame(8'h0F, 3'd4);
    check_frame(10'b1000011110, 434, 1'b1, 1'b0, 8'h00, 3'd0);
    repeat (50) @(negedge clk);
    check_val("post_disturb_idle", 16'({uart_state, rs232_Tx}), 16'b01);

    start_frame(8'hC3, 3'd4);
    k = k_acc;
    done_base = done_seen;
    wait_until(k + 3 + 3 * 434 + 100);
    check_val("pre_rst_bit", 16'(rs232_Tx), 16'd0);
    pulse_reset();
    repeat (10) @(negedge clk);
    check_val("abort_no_done", 16'(done_seen - done_base), 16'd0);
    check_val("abort_idle", 16'({uart_state, rs232_Tx}), 16'b01);
    start_frame(8'h3C, 3'd4);
    check_frame(10'b1001111000, 434, 1'b0, 1'b0, 8'h00, 3'd0);

    probe_period(3'd1, 2604);
    probe_period(3'd2, 1302);
    probe_period(3'd3, 868);
    probe_period(3'd7, 5208);

    repeat (20) @(negedge clk);
    check_val("idle_bps", 16'(idle_bps), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
